// File: rtl/ebr_write_packer.sv
// Packs narrow (16/8/4/2-bit) writes into masked 16-bit row writes for a 16-bit EBR port.
// Latency: mode 0 is 1 cycle; in narrow modes a row leaves when it fills, on a row change, or on flush/mode change/idle timeout.
// Backpressure: s_ready drops while the output register is held (m_valid & !m_ready), during flush, or while a mode change drains.
module ebr_write_packer #(
    parameter int ROW_AW  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        cfg_mode,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ROW_AW+2:0] s_addr,
    input  logic [15:0]       s_data,
    input  logic              flush,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ROW_AW-1:0] m_addr,
    output logic [15:0]       m_data,
    output logic [15:0]       m_mask,
    output logic              busy
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] IDLE_MAX = CW'(TIMEOUT);

    // Mode latched while a partial row is held, so the held row is never reinterpreted.
    logic [1:0]        mode_q;

    // Accumulator for the row currently being assembled.
    logic              acc_vld;
    logic [ROW_AW-1:0] acc_addr;
    logic [15:0]       acc_data;
    logic [15:0]       acc_mask;
    logic [CW-1:0]     idle;

    // Lane decode of the incoming request.
    logic [15:0]       lane_base;
    logic [3:0]        lane_shift;
    logic [15:0]       lane_mask;
    logic [15:0]       lane_data;
    logic [ROW_AW-1:0] s_row;

    // Handshake / control terms.
    logic              slot_free;
    logic              mode_chg;
    logic              accept;
    logic              same_row;
    logic              timeout_hit;
    logic              push_idle;
    logic [15:0]       mrg_data;
    logic [15:0]       mrg_mask;

    // Next-state terms.
    logic              out_ld;
    logic [ROW_AW-1:0] out_addr;
    logic [15:0]       out_data;
    logic [15:0]       out_mask;
    logic              acc_vld_nxt;
    logic [ROW_AW-1:0] acc_addr_nxt;
    logic [15:0]       acc_data_nxt;
    logic [15:0]       acc_mask_nxt;

    assign slot_free   = !m_valid || m_ready;
    assign mode_chg    = acc_vld && (cfg_mode != mode_q);
    assign s_ready     = slot_free && !flush && !mode_chg;
    assign accept      = s_valid && s_ready;
    assign same_row    = acc_vld && (acc_addr == s_row);
    assign timeout_hit = (TIMEOUT != 0) && (idle == IDLE_MAX);
    assign push_idle   = acc_vld && slot_free && (flush || mode_chg || timeout_hit);
    assign mrg_data    = (acc_data & ~lane_mask) | lane_data;
    assign mrg_mask    = acc_mask | lane_mask;
    assign busy        = acc_vld || m_valid;

    // Lane width and bit position from the latched mode; upper address bits fall off in the cast.
    always_comb begin
        lane_base  = 16'hFFFF;
        lane_shift = 4'd0;
        case (mode_q)
            2'd1: begin
                lane_base  = 16'h00FF;
                lane_shift = {s_addr[0], 3'b000};
            end
            2'd2: begin
                lane_base  = 16'h000F;
                lane_shift = {s_addr[1:0], 2'b00};
            end
            2'd3: begin
                lane_base  = 16'h0003;
                lane_shift = {s_addr[2:0], 1'b0};
            end
            default: ;
        endcase
        lane_mask = lane_base << lane_shift;
        lane_data = (s_data & lane_base) << lane_shift;
        s_row     = ROW_AW'(s_addr >> mode_q);
    end

    // Decide what moves into the output register and what the accumulator becomes.
    // An accept takes priority over an idle push; a row change evicts the old row in the same cycle.
    always_comb begin
        out_ld       = 1'b0;
        out_addr     = acc_addr;
        out_data     = acc_data;
        out_mask     = acc_mask;
        acc_vld_nxt  = acc_vld;
        acc_addr_nxt = acc_addr;
        acc_data_nxt = acc_data;
        acc_mask_nxt = acc_mask;
        if (accept) begin
            if (mode_q == 2'd0) begin
                out_ld   = 1'b1;
                out_addr = s_row;
                out_data = s_data;
                out_mask = 16'hFFFF;
            end else if (!acc_vld) begin
                acc_vld_nxt  = 1'b1;
                acc_addr_nxt = s_row;
                acc_data_nxt = lane_data;
                acc_mask_nxt = lane_mask;
            end else if (same_row) begin
                if (mrg_mask == 16'hFFFF) begin
                    out_ld      = 1'b1;
                    out_data    = mrg_data;
                    out_mask    = mrg_mask;
                    acc_vld_nxt = 1'b0;
                end else begin
                    acc_data_nxt = mrg_data;
                    acc_mask_nxt = mrg_mask;
                end
            end else begin
                out_ld       = 1'b1;
                acc_addr_nxt = s_row;
                acc_data_nxt = lane_data;
                acc_mask_nxt = lane_mask;
            end
        end else if (push_idle) begin
            out_ld      = 1'b1;
            acc_vld_nxt = 1'b0;
        end
    end

    // Accumulator, latched mode and idle counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_vld  <= 1'b0;
            acc_addr <= '0;
            acc_data <= '0;
            acc_mask <= '0;
            mode_q   <= 2'd0;
            idle     <= '0;
        end else begin
            acc_vld  <= acc_vld_nxt;
            acc_addr <= acc_addr_nxt;
            acc_data <= acc_data_nxt;
            acc_mask <= acc_mask_nxt;
            if (!acc_vld) begin
                mode_q <= cfg_mode;
            end
            if (TIMEOUT == 0 || accept || push_idle || !acc_vld) begin
                idle <= '0;
            end else if (idle != IDLE_MAX) begin
                idle <= idle + 1'b1;
            end
        end
    end

    // Output register: loads only when the slot is free, otherwise holds until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_addr  <= '0;
            m_data  <= '0;
            m_mask  <= '0;
        end else if (out_ld) begin
            m_valid <= 1'b1;
            m_addr  <= out_addr;
            m_data  <= out_data;
            m_mask  <= out_mask;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
